// File: rtl/cache_line_scheduler.sv
// cache_line_scheduler
//   Replacement controller for a bank of LINES hybrid cache lines. When the
//   cache front end reports a miss, the scheduler either acknowledges at once
//   (the region is already resident in some line) or picks the ready line with
//   the lowest TTL as victim. It then issues flush+fill (dirty victim) or fill
//   only (clean victim), waits for the line to go busy and then idle again,
//   and finally pulses miss_ack.
//
// Ports
//   clk, reset_n   clock and synchronous active-low reset
//   miss_req       front end asks for miss_addr to be made resident (held until miss_ack)
//   miss_addr      address that missed
//   miss_ack       one-cycle pulse: region is resident in line miss_line
//   miss_line      index of the line holding the region (valid with miss_ack)
//   busy           high whenever the controller is not idle
//   timeout_err    sticky: a commanded line never dropped ready
//   line_miss      per-line miss flag (0 = line already holds the region)
//   line_dirty     per-line dirty flag
//   line_ready     per-line ready flag
//   line_ttl       packed per-line TTLs, line i at [i*TTLBITS +: TTLBITS]
//   line_flush     one-hot flush command pulse
//   line_fill      one-hot fill command pulse
//   new_region     line-aligned region to fill
//
// All outputs are registered. Each output register is loaded from the value
// that belongs to the *next* state, so outputs line up with the state they
// describe (e.g. line_fill is high exactly while the FSM sits in ISSUE).

module cache_line_scheduler #(
    parameter int LINES    = 4,
    parameter int IDXBITS  = 2,
    parameter int ADDRBITS = 32,
    parameter int LSBBITS  = 7,
    parameter int TTLBITS  = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     miss_req,
    input  logic [ADDRBITS-1:0]      miss_addr,
    output logic                     miss_ack,
    output logic [IDXBITS-1:0]       miss_line,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic [LINES-1:0]         line_miss,
    input  logic [LINES-1:0]         line_dirty,
    input  logic [LINES-1:0]         line_ready,
    input  logic [LINES*TTLBITS-1:0] line_ttl,
    output logic [LINES-1:0]         line_flush,
    output logic [LINES-1:0]         line_fill,
    output logic [ADDRBITS-1:0]      new_region
);

    localparam int CNTBITS = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } state_t;

    state_t               state, state_next;
    logic [CNTBITS-1:0]   cnt, cnt_next;
    logic [IDXBITS-1:0]   victim, victim_next;
    // Set for the single IDLE cycle that follows ACK, giving the requester
    // time to drop miss_req before it could start a second transaction.
    logic                 holdoff, holdoff_next;

    logic                 miss_ack_next;
    logic [IDXBITS-1:0]   miss_line_next;
    logic                 timeout_err_next;
    logic [LINES-1:0]     line_flush_next;
    logic [LINES-1:0]     line_fill_next;
    logic [ADDRBITS-1:0]  new_region_next;

    // The offset bits of the missing address never reach the region.
    logic unused_offset;
    assign unused_offset = ^miss_addr[LSBBITS-1:0];

    // ------------------------------------------------------------------
    // Hit detection: lowest index whose line already holds the region.
    // ------------------------------------------------------------------
    logic               hit_found;
    logic [IDXBITS-1:0] hit_idx;

    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = 0; i < LINES; i++) begin
            if (!line_miss[i] && !hit_found) begin
                hit_found = 1'b1;
                hit_idx   = IDXBITS'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Victim selection: minimum unsigned TTL among ready lines. The strict
    // '<' keeps the earlier (lower) index on ties.
    // ------------------------------------------------------------------
    logic               sel_found;
    logic [IDXBITS-1:0] sel_idx;
    logic [TTLBITS-1:0] sel_ttl;
    logic [LINES-1:0]   sel_onehot;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_ttl   = '0;
        for (int i = 0; i < LINES; i++) begin
            if (line_ready[i] &&
                (!sel_found || (line_ttl[i*TTLBITS +: TTLBITS] < sel_ttl))) begin
                sel_found = 1'b1;
                sel_idx   = IDXBITS'(i);
                sel_ttl   = line_ttl[i*TTLBITS +: TTLBITS];
            end
        end
        sel_onehot = LINES'(1) << sel_idx;
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_next       = state;
        cnt_next         = cnt;
        victim_next      = victim;
        holdoff_next     = 1'b0;
        miss_ack_next    = 1'b0;
        miss_line_next   = miss_line;
        timeout_err_next = timeout_err;
        line_flush_next  = '0;
        line_fill_next   = '0;
        new_region_next  = new_region;

        unique case (state)
            IDLE: begin
                if (miss_req && !holdoff) begin
                    if (hit_found) begin
                        state_next     = ACK;
                        miss_ack_next  = 1'b1;
                        miss_line_next = hit_idx;
                    end else begin
                        state_next      = SELECT;
                        new_region_next = {miss_addr[ADDRBITS-1:LSBBITS], {LSBBITS{1'b0}}};
                    end
                end
            end

            SELECT: begin
                // With no ready line we simply retry the selection next cycle.
                if (sel_found) begin
                    state_next      = ISSUE;
                    victim_next     = sel_idx;
                    line_fill_next  = sel_onehot;
                    line_flush_next = line_dirty[sel_idx] ? sel_onehot : '0;
                end
            end

            ISSUE: begin
                state_next = WAIT_BUSY;
                cnt_next   = '0;
            end

            WAIT_BUSY: begin
                if (!line_ready[victim]) begin
                    state_next = WAIT_DONE;
                end else if (cnt == CNTBITS'(TIMEOUT)) begin
                    state_next       = IDLE;
                    timeout_err_next = 1'b1;
                end else begin
                    cnt_next = cnt + CNTBITS'(1);
                end
            end

            WAIT_DONE: begin
                // Fill time depends on memory pauses, so there is no bound here.
                if (line_ready[victim]) begin
                    state_next     = ACK;
                    miss_ack_next  = 1'b1;
                    miss_line_next = victim;
                end
            end

            ACK: begin
                state_next   = IDLE;
                holdoff_next = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            victim      <= '0;
            holdoff     <= 1'b0;
            miss_ack    <= 1'b0;
            miss_line   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            line_flush  <= '0;
            line_fill   <= '0;
            new_region  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            victim      <= victim_next;
            holdoff     <= holdoff_next;
            miss_ack    <= miss_ack_next;
            miss_line   <= miss_line_next;
            busy        <= (state_next != IDLE);
            timeout_err <= timeout_err_next;
            line_flush  <= line_flush_next;
            line_fill   <= line_fill_next;
            new_region  <= new_region_next;
        end
    end

endmodule

// File: tb/tb_cache_line_scheduler.sv
// tb_cache_line_scheduler
//   Directed bench for cache_line_scheduler. A table of miss transactions
//   (hits and victim selections) is applied in a loop, followed by
//   hand-written sequences for the multi-cycle corners: long fill, request
//   dropped mid-operation, no eligible line, post-ack holdoff, timeout and
//   reset while waiting. A small behavioural model stands in for the cache
//   lines: on a fill pulse a line drops ready for fill_len cycles.

module tb_cache_line_scheduler;

    localparam int LINES    = 4;
    localparam int IDXBITS  = 2;
    localparam int ADDRBITS = 32;
    localparam int LSBBITS  = 7;
    localparam int TTLBITS  = 8;
    localparam int TIMEOUT  = 15;

    logic                     clk        = 1'b0;
    logic                     reset_n    = 1'b0;
    logic                     miss_req   = 1'b0;
    logic [ADDRBITS-1:0]      miss_addr  = '0;
    logic                     miss_ack;
    logic [IDXBITS-1:0]       miss_line;
    logic                     busy;
    logic                     timeout_err;
    logic [LINES-1:0]         line_miss  = '1;
    logic [LINES-1:0]         line_dirty = '0;
    logic [LINES-1:0]         line_ready;
    logic [LINES*TTLBITS-1:0] line_ttl   = '0;
    logic [LINES-1:0]         line_flush;
    logic [LINES-1:0]         line_fill;
    logic [ADDRBITS-1:0]      new_region;

    int errors = 0;
    int checks = 0;

    // Line model state: mready is the model's own ready, ready_off lets a
    // test hold individual lines not-ready independently of the model.
    int               fill_len [LINES];
    int               lcnt     [LINES];
    logic [LINES-1:0] mready    = '1;
    logic [LINES-1:0] ready_off = '0;

    assign line_ready = mready & ~ready_off;

    always #5 clk = ~clk;

    cache_line_scheduler #(
        .LINES   (LINES),
        .IDXBITS (IDXBITS),
        .ADDRBITS(ADDRBITS),
        .LSBBITS (LSBBITS),
        .TTLBITS (TTLBITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .miss_ack   (miss_ack),
        .miss_line  (miss_line),
        .busy       (busy),
        .timeout_err(timeout_err),
        .line_miss  (line_miss),
        .line_dirty (line_dirty),
        .line_ready (line_ready),
        .line_ttl   (line_ttl),
        .line_flush (line_flush),
        .line_fill  (line_fill),
        .new_region (new_region)
    );

    // Cache line model, evaluated on the falling edge where the registered
    // command outputs are stable. fill_len of 0 models a line that ignores
    // the command and never drops ready.
    always @(negedge clk) begin
        for (int i = 0; i < LINES; i++) begin
            if (!reset_n) begin
                lcnt[i]   = 0;
                mready[i] = 1'b1;
            end else if (line_fill[i] && fill_len[i] != 0) begin
                lcnt[i]   = fill_len[i];
                mready[i] = 1'b0;
            end else if (lcnt[i] != 0) begin
                lcnt[i] = lcnt[i] - 1;
                if (lcnt[i] == 0) mready[i] = 1'b1;
            end
        end
    end

    typedef struct {
        logic [LINES-1:0]         miss;
        logic [LINES-1:0]         dirty;
        logic [LINES-1:0]         roff;
        logic [LINES*TTLBITS-1:0] ttl;    // {line3, line2, line1, line0}
        logic [ADDRBITS-1:0]      addr;
        logic                     hit;
        logic [LINES-1:0]         fill;
        logic [LINES-1:0]         flush;
        logic [IDXBITS-1:0]       line;
        logic [ADDRBITS-1:0]      region;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete miss transaction. Cycles are counted in falling edges
    // after miss_req is raised. drop_at > 0 releases miss_req at that cycle.
    task automatic run_txn(input vec_t v, input string tag, input int len, input int drop_at);
        logic [LINES-1:0]    fill_or;
        logic [LINES-1:0]    flush_or;
        int                  fill_cycles;
        int                  fill_at;
        int                  ack_at;
        logic [ADDRBITS-1:0] region;
        logic [IDXBITS-1:0]  line;
        logic                saw_err;

        repeat (2) @(negedge clk);
        line_miss  = v.miss;
        line_dirty = v.dirty;
        ready_off  = v.roff;
        line_ttl   = v.ttl;
        miss_addr  = v.addr;
        for (int i = 0; i < LINES; i++) fill_len[i] = len;
        fill_or = '0; flush_or = '0; fill_cycles = 0; fill_at = -1; ack_at = -1;
        region = '0; line = '0; saw_err = 1'b0;
        miss_req = 1'b1;

        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == drop_at) miss_req = 1'b0;
            if (line_fill != '0 || line_flush != '0) begin
                fill_or     = fill_or | line_fill;
                flush_or    = flush_or | line_flush;
                fill_cycles = fill_cycles + 1;
                fill_at     = c;
                region      = new_region;
            end
            if (timeout_err) saw_err = 1'b1;
            if (miss_ack) begin
                ack_at = c;
                line   = miss_line;
                break;
            end
        end
        miss_req = 1'b0;

        check({tag, " ack seen"},    32'(ack_at > 0), 32'd1);
        check({tag, " fill"},        32'(fill_or),    32'(v.fill));
        check({tag, " flush"},       32'(flush_or),   32'(v.flush));
        check({tag, " cmd cycles"},  32'(fill_cycles), v.hit ? 32'd0 : 32'd1);
        check({tag, " miss_line"},   32'(line),       32'(v.line));
        check({tag, " timeout_err"}, 32'(saw_err),    32'd0);
        if (v.hit) begin
            check({tag, " hit latency"}, 32'(ack_at), 32'd1);
        end else begin
            check({tag, " new_region"},   region,           v.region);
            check({tag, " issue cycle"},  32'(fill_at),     32'd2);
            check({tag, " fill latency"}, 32'(ack_at - fill_at), 32'(len + 1));
        end
    endtask

    initial begin
        int   n;
        logic seen;

        for (int i = 0; i < LINES; i++) begin
            fill_len[i] = 3;
            lcnt[i]     = 0;
        end

        // miss, dirty, roff, ttl{l3,l2,l1,l0}, addr, hit, fill, flush, line, region
        vecs[0] = '{4'b1011, 4'b0000, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 32'h0000_1234,
                    1'b1, 4'b0000, 4'b0000, 2'd2, 32'h0};
        vecs[1] = '{4'b0100, 4'b1111, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 32'h0000_5678,
                    1'b1, 4'b0000, 4'b0000, 2'd0, 32'h0};
        vecs[2] = '{4'b1111, 4'b0000, 4'b0000, {8'd40, 8'd10, 8'd30, 8'd20}, 32'h0000_1234,
                    1'b0, 4'b0100, 4'b0000, 2'd2, 32'h0000_1200};
        vecs[3] = '{4'b1111, 4'b0001, 4'b0000, {8'd5, 8'd5, 8'd5, 8'd5}, 32'hFFFF_FFFF,
                    1'b0, 4'b0001, 4'b0001, 2'd0, 32'hFFFF_FF80};
        vecs[4] = '{4'b1111, 4'b0010, 4'b0010, {8'd30, 8'd20, 8'd5, 8'd9}, 32'h0000_007F,
                    1'b0, 4'b0001, 4'b0000, 2'd0, 32'h0000_0000};
        vecs[5] = '{4'b1111, 4'b1000, 4'b0000, {8'h01, 8'hFF, 8'h80, 8'h7F}, 32'hABCD_EF80,
                    1'b0, 4'b1000, 4'b1000, 2'd3, 32'hABCD_EF80};
        vecs[6] = '{4'b1111, 4'b1101, 4'b0000, {8'd9, 8'd9, 8'd2, 8'd9}, 32'h8000_00FF,
                    1'b0, 4'b0010, 4'b0000, 2'd1, 32'h8000_0080};
        vecs[7] = '{4'b0111, 4'b0000, 4'b0000, {8'd1, 8'd2, 8'd3, 8'd4}, 32'h0000_0000,
                    1'b1, 4'b0000, 4'b0000, 2'd3, 32'h0};

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst miss_ack",    32'(miss_ack),    32'd0);
        check("rst miss_line",   32'(miss_line),   32'd0);
        check("rst busy",        32'(busy),        32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        check("rst line_flush",  32'(line_flush),  32'd0);
        check("rst line_fill",   32'(line_fill),   32'd0);
        check("rst new_region",  new_region,       32'd0);
        #1 reset_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("v%0d", i), 3, 0);

        // ---------------- long fill: 32 cycles not ready ----------------
        run_txn(vecs[2], "long fill", 32, 0);

        // ---------------- miss_req dropped after ISSUE ----------------
        run_txn(vecs[3], "req dropped", 4, 3);

        // ---------------- no eligible line: hold in SELECT ----------------
        repeat (2) @(negedge clk);
        line_miss = '1; line_dirty = '0; line_ttl = {8'd40, 8'd10, 8'd30, 8'd20};
        miss_addr = 32'h0000_2000; ready_off = 4'b1111;
        for (int i = 0; i < LINES; i++) fill_len[i] = 3;
        miss_req = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (line_fill != '0 || line_flush != '0 || miss_ack) seen = 1'b1;
        end
        check("stall busy",     32'(busy), 32'd1);
        check("stall no cmds",  32'(seen), 32'd0);
        ready_off = 4'b1110;   // only line 0 becomes eligible
        n = 0;
        while (line_fill == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("stall fill", 32'(line_fill), 32'b0001);
        n = 0;
        while (!miss_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall ack",  32'(miss_ack),  32'd1);
        check("stall line", 32'(miss_line), 32'd0);
        miss_req = 1'b0;
        ready_off = '0;

        // ---------------- post-ack holdoff with request held ----------------
        repeat (2) @(negedge clk);
        line_miss = 4'b1011;
        miss_req  = 1'b1;
        @(negedge clk); check("holdoff ack c1", 32'(miss_ack), 32'd1);
        @(negedge clk); check("holdoff ack c2", 32'(miss_ack), 32'd0);
        @(negedge clk); check("holdoff ack c3", 32'(miss_ack), 32'd0);
        check("holdoff busy c3", 32'(busy), 32'd0);
        @(negedge clk); check("holdoff ack c4", 32'(miss_ack), 32'd1);
        miss_req = 1'b0;

        // ---------------- timeout: line never drops ready ----------------
        repeat (2) @(negedge clk);
        line_miss = '1; line_dirty = '0; line_ttl = {8'd40, 8'd10, 8'd30, 8'd20};
        for (int i = 0; i < LINES; i++) fill_len[i] = 0;
        miss_req = 1'b1;
        n = 0;
        while (line_fill == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("to fill", 32'(line_fill), 32'b0100);
        seen = 1'b0;
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            @(negedge clk);
            if (miss_ack) seen = 1'b1;
            if (k == TIMEOUT + 1) begin
                check("to busy before",  32'(busy),        32'd1);
                check("to err before",   32'(timeout_err), 32'd0);
            end
        end
        miss_req = 1'b0;
        check("to busy after", 32'(busy),        32'd0);
        check("to err after",  32'(timeout_err), 32'd1);
        check("to no ack",     32'(seen),        32'd0);
        repeat (5) @(negedge clk);
        check("to err sticky", 32'(timeout_err), 32'd1);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("to err cleared", 32'(timeout_err), 32'd0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < LINES; i++) fill_len[i] = 3;

        // ---------------- reset while in WAIT_DONE ----------------
        run_txn(vecs[6], "pre-reset", 3, 0);   // leaves miss_line=1
        repeat (2) @(negedge clk);
        line_miss = '1; line_dirty = '0; line_ttl = {8'd40, 8'd10, 8'd30, 8'd20};
        miss_addr = 32'h0000_1234;
        for (int i = 0; i < LINES; i++) fill_len[i] = 50;
        miss_req = 1'b1;
        n = 0;
        while (line_fill == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        miss_req = 1'b0;
        check("wd busy", 32'(busy), 32'd1);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("wd rst busy",       32'(busy),        32'd0);
        check("wd rst miss_ack",   32'(miss_ack),    32'd0);
        check("wd rst miss_line",  32'(miss_line),   32'd0);
        check("wd rst fill",       32'(line_fill),   32'd0);
        check("wd rst flush",      32'(line_flush),  32'd0);
        check("wd rst new_region", new_region,       32'd0);
        #1 reset_n = 1'b1;
        run_txn(vecs[3], "post-reset", 3, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_line_scheduler.md
Name: cache_line_scheduler

Overview:
- Replacement controller for a bank of LINES hybrid cache lines.
- On a miss request from the dcache/icache front end, it picks a victim line by lowest TTL. It then issues flush+fill (dirty victim) or fill only (clean victim), and waits for the line to finish before acknowledging.
- Sits between the cache front end and the cache_line instances' controller-side ports.

Parameters:
- LINES, 4, number of cache lines managed.
- IDXBITS, 2, width of line index; LINES must equal 2**IDXBITS.
- ADDRBITS, 32, address width.
- LSBBITS, 7, line offset bits (line = 2**LSBBITS bytes).
- TTLBITS, 8, width of each line's TTL.
- TIMEOUT, 15, max cycles to wait for a line to drop ready after a command.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- miss_req  in  1  front end requests that miss_addr be made resident; held until miss_ack.
- miss_addr  in  ADDRBITS  address that missed; stable while miss_req=1.
- miss_ack  out  1  one-cycle pulse: the region for miss_addr is resident.
- miss_line  out  IDXBITS  index of the line holding the region; valid with miss_ack.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky; set when a commanded line never dropped ready; cleared only by reset.
- line_miss  in  LINES  per-line cache_line_miss.
- line_dirty  in  LINES  per-line cache_line_dirty.
- line_ready  in  LINES  per-line cache_line_ready.
- line_ttl  in  LINES*TTLBITS  packed TTLs, line i at [i*TTLBITS +: TTLBITS].
- line_flush  out  LINES  one-hot flush command pulse.
- line_fill  out  LINES  one-hot fill command pulse.
- new_region  out  ADDRBITS  region for the fill: {miss_addr[ADDRBITS-1:LSBBITS], LSBBITS'b0}.

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE; miss_ack=0, miss_line=0, busy=0, timeout_err=0, line_flush=0, line_fill=0, new_region=0. All outputs are registered.
- IDLE:
  - If miss_req=1 and any line_miss[i]=0 (region already resident), go to ACK with miss_line = lowest such i. No commands are issued.
  - Otherwise, if miss_req=1, latch new_region and go to SELECT.
- SELECT (1 cycle): victim = index with minimum line_ttl; ties go to the lowest index. Comparison is unsigned on the TTLBITS-wide value. Only lines with line_ready=1 are eligible. If none are eligible, stay in SELECT. Go to ISSUE.
- ISSUE (1 cycle):
  - Drive exactly one bit high, in exactly one cycle: line_flush[v]=1 if line_dirty[v]=1 at that cycle.
  - Drive line_fill[v]=1 in the same cycle regardless.
  - Load the timeout counter with 0. Go to WAIT_BUSY.
- WAIT_BUSY: the counter increments each cycle.
  - If line_ready[v]=0, go to WAIT_DONE.
  - If the counter reaches TIMEOUT with ready still 1: set timeout_err and go to IDLE with no ack. The front end retries by keeping miss_req asserted.
- WAIT_DONE: wait for line_ready[v]=1, with no timeout (the fill duration depends on memory pause). Then go to ACK.
- ACK (1 cycle): miss_ack=1, miss_line=v (or the hit index). Go to IDLE.
  - IDLE ignores miss_req in the cycle right after ACK, so the requester has one cycle to drop the request.
- Command outputs and miss_ack are zero in every state except their own single cycle.
- miss_req deasserted mid-operation: the sequence still completes; miss_ack is still pulsed and may be ignored.
- miss_addr changing while busy: no effect; new_region is latched in IDLE.
- Reset mid-operation: immediate return to IDLE and all outputs zero. Lines are reset by the same reset_n.
- Latency, clean victim, line responding immediately: IDLE→SELECT→ISSUE→WAIT_BUSY→WAIT_DONE…→ACK. miss_ack comes ≥4 cycles after miss_req plus the fill duration.

Test Plan:
- Hit bypass: LINES=4, line_miss=4'b1011, miss_req=1 → miss_ack 1 cycle later with miss_line=2; line_fill/line_flush stay 0.
- Clean victim: ttl={40,10,30,20} for lines 3..0, dirty=0, all ready, miss_addr=0x0000_1234 → line_fill=4'b0100 for one cycle, line_flush=0, new_region=0x0000_1200. Model line 2 as not ready for 32 cycles → miss_ack with miss_line=2 one cycle after ready returns.
- Dirty victim with tie: ttl all =5, dirty=4'b0001 → line_flush=4'b0001 and line_fill=4'b0001 in the same cycle; miss_line=0.
- Ineligible minimum: line 1 has the lowest TTL but line_ready[1]=0 → victim is the next-lowest ready line. Once all lines are not ready, stay in SELECT (busy=1, no commands) until one becomes ready.
- Timeout: the commanded line never drops ready → after TIMEOUT+1 cycles in WAIT_BUSY, timeout_err=1, state IDLE, no miss_ack; timeout_err stays 1 until reset_n=0.
- Reset in WAIT_DONE: assert reset_n=0 for 1 cycle → next cycle busy=0, all outputs 0. A new miss_req is then processed normally.
